// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the gcd_stream binary GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The step counter must hold 2*width, the worst-case reduction count.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

    // The common power of two never exceeds width-1.
    function automatic int k_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One reduction step of the binary (Stein) GCD: next x/y/k/count plus the
// terminal flag and the final shifted result when a terminal rule fires.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH),
    localparam int K_W = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [K_W-1:0]   k,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] next_x,
    output logic [WIDTH-1:0] next_y,
    output logic [K_W-1:0]   next_k,
    output logic [CNT_W-1:0] next_count,
    output logic             terminal,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        next_x     = x;
        next_y     = y;
        next_k     = k;
        next_count = count;
        terminal   = 1'b0;
        result     = '0;

        if (x == '0) begin
            terminal = 1'b1;
            result   = y << k;
        end else if (y == '0) begin
            terminal = 1'b1;
            result   = x << k;
        end else begin
            next_count = count + CNT_W'(1);
            if (!x[0] && !y[0]) begin
                next_x = x >> 1;
                next_y = y >> 1;
                next_k = k + K_W'(1);
            end else if (!x[0]) begin
                next_x = x >> 1;
            end else if (!y[0]) begin
                next_y = y >> 1;
            end else if (x >= y) begin
                // Both odd: the difference is even, so halving loses nothing.
                next_x = (x - y) >> 1;
            end else begin
                next_y = (y - x) >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_stream.sv
// Streaming binary GCD engine: accepts one operand pair, reduces it one step
// per clock, and presents gcd, both-zero flag and step count until taken.
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_val,
    output logic             zero_flag,
    output logic [CNT_W-1:0] steps
);

    localparam int K_W = k_width(WIDTH);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic [K_W-1:0]   k_next;
    logic [CNT_W-1:0] count_next;
    logic             terminal;
    logic [WIDTH-1:0] step_result;

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x          (x),
        .y          (y),
        .k          (k),
        .count      (count),
        .next_x     (x_next),
        .next_y     (y_next),
        .next_k     (k_next),
        .next_count (count_next),
        .terminal   (terminal),
        .result     (step_result)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = CALC;
            CALC:    if (terminal) state_next = DONE;
            DONE:    if (deliver)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            k         <= '0;
            count     <= '0;
            gcd_val   <= '0;
            zero_flag <= 1'b0;
            steps     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x         <= a;
                        y         <= b;
                        k         <= '0;
                        count     <= '0;
                        zero_flag <= (a == '0) && (b == '0);
                    end
                end
                CALC: begin
                    if (terminal) begin
                        gcd_val <= step_result;
                        steps   <= count;
                    end else begin
                        x     <= x_next;
                        y     <= y_next;
                        k     <= k_next;
                        count <= count_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stream.sv
// Self-checking bench for gcd_stream: directed 8-bit scenarios plus an
// exhaustive 4-bit sweep, with a scoreboard of expected results.
module tb_gcd_stream;

    localparam int W   = 8;
    localparam int CW  = $clog2(2 * W + 1);
    localparam int W4  = 4;
    localparam int CW4 = $clog2(2 * W4 + 1);

    typedef struct {
        logic [W-1:0]  g;
        logic          zf;
        logic [CW-1:0] st;
        bit            st_known;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    logic          in_valid, in_ready, out_valid, out_ready, zero_flag;
    logic [W-1:0]  a, b, gcd_val;
    logic [CW-1:0] steps;

    logic           in_valid4, in_ready4, out_valid4, out_ready4, zero_flag4;
    logic [W4-1:0]  a4, b4, gcd_val4;
    logic [CW4-1:0] steps4;

    exp_t          sb[$];
    logic [W4-1:0] sb4[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd_val   (gcd_val),
        .zero_flag (zero_flag),
        .steps     (steps)
    );

    gcd_stream #(.WIDTH(W4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .gcd_val   (gcd_val4),
        .zero_flag (zero_flag4),
        .steps     (steps4)
    );

    // Euclid by remainder: an independent reference for the Stein engine.
    function automatic int ref_gcd(input int p, input int q);
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] g, input logic zf, input int st, input bit known);
        exp_t e;
        e.g        = g;
        e.zf       = zf;
        e.st       = CW'(st);
        e.st_known = known;
        sb.push_back(e);
    endtask

    // Waits for a result, compares it with the scoreboard head, then takes it.
    task automatic collect(input string name, input int exp_lat);
        exp_t e;
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s result_timeout out_valid=%b required=1", name, out_valid);
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected_result gcd_val=%0d required=none", name, gcd_val);
            return;
        end
        e = sb.pop_front();
        if (exp_lat >= 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s latency got=%0d required=%0d", name, lat, exp_lat);
            end
        end
        checks++;
        if (gcd_val !== e.g) begin
            errors++;
            $display("FAIL %s gcd_val got=%0d required=%0d", name, gcd_val, e.g);
        end
        checks++;
        if (zero_flag !== e.zf) begin
            errors++;
            $display("FAIL %s zero_flag got=%b required=%b", name, zero_flag, e.zf);
        end
        checks++;
        if (e.st_known ? (steps !== e.st) : ($isunknown(steps) || steps > CW'(2 * W))) begin
            errors++;
            $display("FAIL %s steps got=%0d required=%0d known=%0d", name, steps, e.st, e.st_known);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s return_to_idle in_ready=%b out_valid=%b required=1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic run_pair(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] g, input logic zf, input int st);
        drive(av, bv);
        push_exp(g, zf, st, 1'b1);
        collect($sformatf("pair_%0d_%0d", av, bv), st + 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required=1/0", in_ready, out_valid);
        end
        checks++;
        if (gcd_val !== '0 || zero_flag !== 1'b0 || steps !== '0) begin
            errors++;
            $display("FAIL reset_results gcd=%0d zf=%b steps=%0d required=0/0/0", gcd_val, zero_flag, steps);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || gcd_val4 !== '0) begin
            errors++;
            $display("FAIL reset_w4 in_ready=%b out_valid=%b gcd=%0d required=1/0/0", in_ready4, out_valid4, gcd_val4);
        end
    endtask

    task automatic test_basic();
        run_pair(8'd12,  8'd18,  8'd6,   1'b0, 4);
        run_pair(8'd128, 8'd96,  8'd32,  1'b0, 9);
        run_pair(8'd7,   8'd0,   8'd7,   1'b0, 0);
        run_pair(8'd0,   8'd0,   8'd0,   1'b1, 0);
        run_pair(8'd255, 8'd255, 8'd255, 1'b0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] av, bv;
            av = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            drive(av, bv);
            push_exp(W'(ref_gcd(int'(av), int'(bv))), (av == 0) && (bv == 0), 0, 1'b0);
            collect($sformatf("rand_%0d_%0d", av, bv), -1);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        drive(8'd12, 8'd18);
        push_exp(8'd6, 1'b0, 4, 1'b1);
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        // Offer a new pair while the result waits; it must be ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 8'd3;
            b = 8'd5;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_handshake cyc=%0d out_valid=%b in_ready=%b required=1/0", i, out_valid, in_ready);
            end
            checks++;
            if (gcd_val !== 8'd6 || steps !== CW'(4)) begin
                errors++;
                $display("FAIL bp_hold_value cyc=%0d gcd=%0d steps=%0d required=6/4", i, gcd_val, steps);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect("backpressure", -1);
        checks++;
        if (gcd_val !== 8'd6) begin
            errors++;
            $display("FAIL bp_result_kept gcd=%0d required=6", gcd_val);
        end
    endtask

    task automatic test_reset_mid_calc();
        drive(8'd128, 8'd96);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_handshake in_ready=%b out_valid=%b required=1/0", in_ready, out_valid);
        end
        checks++;
        if (gcd_val !== '0 || zero_flag !== 1'b0 || steps !== '0) begin
            errors++;
            $display("FAIL midreset_results gcd=%0d zf=%b steps=%0d required=0/0/0", gcd_val, zero_flag, steps);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_result cyc=%0d out_valid=%b required=0", i, out_valid);
            end
        end
        run_pair(8'd9, 8'd6, 8'd3, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int accepts = 0;
        int n = 0;
        exp_t e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'd12;
        b = 8'd18;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (gcd_val !== e.g) begin
                    errors++;
                    $display("FAIL b2b_gcd cyc=%0d got=%0d required=%0d", cyc, gcd_val, e.g);
                end
            end
            if (in_ready === 1'b1) begin
                push_exp(8'd6, 1'b0, 4, 1'b1);
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 7) begin
                        errors++;
                        $display("FAIL b2b_interval got=%0d required=7", cyc - last);
                    end
                end
                last = cyc;
                accepts++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        while (sb.size() > 0 && n < 100) begin
            if (out_valid === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (gcd_val !== e.g) begin
                    errors++;
                    $display("FAIL b2b_drain_gcd got=%0d required=%0d", gcd_val, e.g);
                end
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (accepts < 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count accepts=%0d pending=%0d required>=4/0", accepts, sb.size());
        end
    endtask

    task automatic test_sweep_w4();
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                int  n = 0;
                bit  done = 1'b0;
                bit  seen = 1'b0;
                bit  take;
                logic [W4-1:0] g;
                while (!in_ready4 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                in_valid4 = 1'b1;
                a4 = W4'(ai);
                b4 = W4'(bi);
                @(negedge clk);
                in_valid4 = 1'b0;
                sb4.push_back(W4'(ref_gcd(ai, bi)));
                n = 0;
                while (!done && n < 200) begin
                    if (out_valid4 === 1'b1 && !seen) begin
                        seen = 1'b1;
                        g = sb4.pop_front();
                        checks++;
                        if (gcd_val4 !== g || zero_flag4 !== (ai == 0 && bi == 0)) begin
                            errors++;
                            $display("FAIL sweep_gcd a=%0d b=%0d got=%0d/%b required=%0d/%b",
                                     ai, bi, gcd_val4, zero_flag4, g, (ai == 0 && bi == 0));
                        end
                        checks++;
                        if ($isunknown(steps4) || steps4 > CW4'(2 * W4)) begin
                            errors++;
                            $display("FAIL sweep_steps a=%0d b=%0d got=%0d required<=%0d", ai, bi, steps4, 2 * W4);
                        end
                    end
                    out_ready4 = 1'($urandom_range(0, 1));
                    take = (out_valid4 === 1'b1) && out_ready4;
                    @(negedge clk);
                    n++;
                    if (take) done = 1'b1;
                end
                out_ready4 = 1'b0;
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_timeout a=%0d b=%0d out_valid=%b required=1", ai, bi, out_valid4);
                    sb4.delete();
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        a4         = '0;
        b4         = '0;
        @(negedge clk);

        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_sweep_w4();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gcd_stream.md
Name: gcd_stream

Overview:
- Parametrised binary (Stein) GCD engine; WIDTH-bit unsigned operands.
- Valid/ready handshake on input and output.
- Reports a step count and a both-zero flag alongside the result.
- Sits between an operand producer and a result consumer; one operand pair is in flight at a time; back-pressure is honoured on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(2*WIDTH+1), width of step counter. Derived localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer accepts the result.
- gcd_val  out  WIDTH  gcd(a,b); gcd(x,0)=x; gcd(0,0)=0.
- zero_flag  out  1  both operands were zero.
- steps  out  CNT_W  number of reduction steps taken.

Behaviour:
- Reset: one clock, reset high, synchronous, active-high.
  - state=IDLE, in_ready=1, out_valid=0, gcd_val=0, zero_flag=0, steps=0.
  - Internal x, y, k and step counter are cleared.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is presented.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). Registered outputs change only on clk.
- IDLE:
  - On in_valid && in_ready, capture x<=a, y<=b, k<=0, count<=0.
  - Set zero_flag<=(a==0 && b==0) and go to CALC.
- CALC: exactly one rule per cycle, in this priority order:
  1. x==0: gcd_val<=y<<k, steps<=count, go to DONE (terminal).
  2. y==0: gcd_val<=x<<k, steps<=count, go to DONE (terminal).
  3. x,y both even: x>>=1, y>>=1, k++, count++.
  4. x even: x>>=1, count++.
  5. y even: y>>=1, count++.
  6. Both odd, x>=y: x<=(x-y)>>1, count++.
  7. Both odd, x<y: y<=(y-x)>>1, count++.
- Width rules:
  - Subtraction is performed only when the minuend >= the subtrahend, so it never wraps.
  - k <= WIDTH-1 whenever a left shift is applied, and the shifted result fits in WIDTH bits.
- Termination and latency:
  - Each non-terminal step removes >= 1 bit from x or y, so count <= 2*WIDTH.
  - out_valid rises (steps+1) edges after the accepting edge.
- DONE:
  - out_valid=1; gcd_val, zero_flag and steps are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_valid; the result registers keep their values.
  - in_ready stays 0 in DONE, so accept and deliver never occur in the same cycle.
  - out_ready held high continuously gives a throughput of one result per (steps+3) cycles.
- in_valid outside IDLE is ignored. a and b are sampled only on the accepting edge.

Decomposition:
- Package gcd_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Function for the CNT_W computation.
- Sub-module gcd_step (combinational): takes x, y, k, count and returns the next x, y, k, count and a terminal flag.
  - Isolates rules 1-7 so it can be checked exhaustively at WIDTH=4.
- Top level: FSM, handshake and result registers.

Test Plan:
- WIDTH=8, a=12, b=18 -> gcd_val=6, steps=4, out_valid 5 edges after accept, zero_flag=0.
- a=128, b=96 -> gcd_val=32, steps=9. Also a=7, b=0 -> gcd_val=7, steps=0, out_valid 1 edge after accept.
- a=0, b=0 -> gcd_val=0, zero_flag=1, steps=0. Also a=255, b=255 -> gcd_val=255, steps=1.
- Result accepted with out_ready held low 10 cycles -> out_valid, gcd_val and steps stable throughout, in_ready=0. Then out_ready=1 -> IDLE next edge, in_ready=1.
- reset asserted for 1 cycle during CALC of (128,96) -> next edge all outputs at reset values. A fresh (9,6) then completes normally: gcd_val=3.
- WIDTH=4 exhaustive sweep, all 256 pairs, random out_ready -> gcd_val matches a reference model and steps <= 8 for every pair.
